// File: rtl/ahb_subordinate_mem.sv
// AHB-Lite subordinate fronting a word-organised 32-bit RAM with configurable wait states.
// Define AHB_SUB_ERR_EN to enable address-range, alignment and size checks with ERROR responses.
module ahb_subordinate_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             p_write;
  logic [IDX_W-1:0] p_idx;
  logic [3:0]       p_lanes;
  logic [31:0]      mem [MEM_DEPTH];

  logic             accept;
  logic [31:0]      offset;
  logic [IDX_W-1:0] acc_idx;
  logic [3:0]       acc_lanes;
  logic             acc_err;
  logic             commit;
  logic [31:0]      merged;
  logic [31:0]      acc_rdata;
  logic             unused_bits;

  // Address decode, lane selection and write-to-read forwarding for the incoming transfer.
  always_comb begin
    accept  = HSEL & HTRANS[1] & HREADY;
    offset  = HADDR - BASE_ADDR;
    acc_idx = offset[IDX_W+1:2];
    case (HSIZE)
      3'b000:  acc_lanes = 4'b0001 << HADDR[1:0];
      3'b001:  acc_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: acc_lanes = 4'b1111;
    endcase
`ifdef AHB_SUB_ERR_EN
    acc_err = ({1'b0, HADDR} < 33'(BASE_ADDR)) ||
              ({1'b0, HADDR} >= 33'(BASE_ADDR) + 33'(4 * MEM_DEPTH)) ||
              ((HSIZE == 3'b001) && HADDR[0]) ||
              ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) ||
              (HSIZE > 3'b010);
`else
    acc_err = 1'b0;
`endif
    commit = (state == ST_DATA) && p_write;
    merged = mem[p_idx];
    for (int i = 0; i < 4; i++) begin
      if (p_lanes[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
    end
    acc_rdata = (commit && (acc_idx == p_idx)) ? merged : mem[acc_idx];
  end

  assign unused_bits = ^{HTRANS[0], offset[1:0], offset[31:IDX_W+2]};

  // Write data arrives in the DATA cycle and lands at the edge that ends it.
  always_ff @(posedge HCLK) begin
    if (commit) mem[p_idx] <= merged;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      p_write   <= 1'b0;
      p_idx     <= '0;
      p_lanes   <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
            if (!p_write) HRDATA <= mem[p_idx];
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and the second ERROR cycle can all take a new address phase.
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          if (accept) begin
            p_write <= HWRITE;
            p_idx   <= acc_idx;
            p_lanes <= acc_lanes;
            if (acc_err) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state <= ST_DATA;
              if (!HWRITE) HRDATA <= acc_rdata;
            end else begin
              state     <= ST_WAIT;
              HREADYOUT <= 1'b0;
              wait_cnt  <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
      endcase
    end
  end

endmodule
